tick_sequencer: RTL and testbench

//  Per-tick game-update scheduler. Consumes the level tick from the tick generator.

---
 rtl/tick_sequencer.sv | 252 +++++++++++++++++++++++++
 tb/tb_tick_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_sequencer.sv
// -----------------------------------------------------------------------------
// tick_sequencer
//   Per-tick game-update scheduler. Each level tick from the tick generator is
//   turned into a sequence of board-datapath phases (COLLIDE, MOVE, SPAWN)
//   driven over a req/ack handshake. Score, game-over and timeout state are
//   kept here, and o_tick_done tells the tick generator to drop its tick.
//
// Ports
//   clk          in   1        clock
//   rst_n        in   1        synchronous active-low reset
//   i_tick       in   1        level tick request, held until o_tick_done
//   i_restart    in   1        restart button level, rising edge restarts
//   i_ack        in   1        datapath finished current phase (pulse)
//   i_result     in   1        phase result with i_ack (hit / ate / ok)
//   o_req        out  1        phase request, high while waiting for i_ack
//   o_phase      out  3        0 NONE, 1 INIT, 2 COLLIDE, 3 MOVE, 4 SPAWN
//   o_tick_done  out  1        one-cycle pulse, tick fully processed
//   o_game_over  out  1        sticky collision flag, cleared by INIT
//   o_score      out  SCORE_W  food eaten since INIT, saturating
//   o_timeout    out  1        sticky, a phase hit ACK_TIMEOUT since INIT
// -----------------------------------------------------------------------------
module tick_sequencer #(
    parameter int unsigned SCORE_W       = 8,
    parameter int unsigned ACK_TIMEOUT   = 15,
    parameter int unsigned SPAWN_RETRIES = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_tick,
    input  logic               i_restart,
    input  logic               i_ack,
    input  logic               i_result,
    output logic               o_req,
    output logic [2:0]         o_phase,
    output logic               o_tick_done,
    output logic               o_game_over,
    output logic [SCORE_W-1:0] o_score,
    output logic               o_timeout
);

    localparam int unsigned WAIT_W    = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam int unsigned WAIT_LAST = ACK_TIMEOUT - 1;
    localparam int unsigned RETRY_W   = (SPAWN_RETRIES < 1) ? 1 : $clog2(SPAWN_RETRIES + 1);

    localparam logic [2:0] PH_NONE    = 3'd0;
    localparam logic [2:0] PH_INIT    = 3'd1;
    localparam logic [2:0] PH_COLLIDE = 3'd2;
    localparam logic [2:0] PH_MOVE    = 3'd3;
    localparam logic [2:0] PH_SPAWN   = 3'd4;

    // S_GAP is the one-cycle request-low handoff between two phase requests.
    typedef enum logic [2:0] {
        S_RST     = 3'd0,
        S_INIT    = 3'd1,
        S_IDLE    = 3'd2,
        S_COLLIDE = 3'd3,
        S_MOVE    = 3'd4,
        S_SPAWN   = 3'd5,
        S_DONE    = 3'd6,
        S_GAP     = 3'd7
    } state_e;

    state_e               state_q,     state_d;
    state_e               gap_tgt_q,   gap_tgt_d;
    logic [WAIT_W-1:0]    wait_q,      wait_d;
    logic [RETRY_W-1:0]   retry_q,     retry_d;
    logic [SCORE_W-1:0]   score_q,     score_d;
    logic                 game_over_q, game_over_d;
    logic                 timeout_q,   timeout_d;
    logic                 prev_restart_q;
    logic                 req_q,       req_d;
    logic [2:0]           phase_q,     phase_d;
    logic                 tick_done_q, tick_done_d;

    logic                 in_phase;
    logic                 ack_seen;
    logic                 expired;
    logic                 complete;
    logic                 result;
    logic                 restart_edge;

    // Next-state, bookkeeping and output decode.
    always_comb begin
        state_d     = state_q;
        gap_tgt_d   = gap_tgt_q;
        wait_d      = '0;
        retry_d     = retry_q;
        score_d     = score_q;
        game_over_d = game_over_q;
        timeout_d   = timeout_q;
        req_d       = 1'b0;
        phase_d     = PH_NONE;
        tick_done_d = 1'b0;

        in_phase     = (state_q == S_INIT) || (state_q == S_COLLIDE) ||
                       (state_q == S_MOVE) || (state_q == S_SPAWN);
        ack_seen     = in_phase && i_ack;
        expired      = in_phase && !i_ack && (wait_q == WAIT_W'(WAIT_LAST));
        complete     = ack_seen || expired;
        // A forced completion is treated as a zero result.
        result       = ack_seen && i_result;
        restart_edge = i_restart && !prev_restart_q && (state_q != S_RST);

        if (in_phase && !complete) begin
            wait_d = wait_q + WAIT_W'(1);
        end
        if (expired) begin
            timeout_d = 1'b1;
        end

        case (state_q)
            S_RST: begin
                state_d = S_INIT;
            end
            S_INIT: begin
                if (complete) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (i_tick) begin
                    state_d = game_over_q ? S_DONE : S_COLLIDE;
                end
            end
            S_COLLIDE: begin
                if (complete) begin
                    if (result) begin
                        game_over_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        gap_tgt_d = S_MOVE;
                        state_d   = S_GAP;
                    end
                end
            end
            S_MOVE: begin
                if (complete) begin
                    if (result) begin
                        if (score_q != {SCORE_W{1'b1}}) begin
                            score_d = score_q + SCORE_W'(1);
                        end
                        retry_d   = '0;
                        gap_tgt_d = S_SPAWN;
                        state_d   = S_GAP;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SPAWN: begin
                if (complete) begin
                    if (result) begin
                        state_d = S_DONE;
                    end else if (retry_q < RETRY_W'(SPAWN_RETRIES)) begin
                        retry_d   = retry_q + RETRY_W'(1);
                        gap_tgt_d = S_SPAWN;
                        state_d   = S_GAP;
                    end else begin
                        // Board full or unlucky: give up for this tick.
                        state_d = S_DONE;
                    end
                end
            end
            S_GAP: begin
                state_d = gap_tgt_q;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_RST;
            end
        endcase

        // Restart abandons any outstanding phase; its result is discarded
        // because INIT entry below wipes everything the ack may have touched.
        if (restart_edge) begin
            state_d = S_INIT;
            wait_d  = '0;
        end

        if (restart_edge || (state_q == S_RST)) begin
            score_d     = '0;
            game_over_d = 1'b0;
            timeout_d   = 1'b0;
            retry_d     = '0;
        end

        // Moore outputs, decoded from the next state and registered.
        case (state_d)
            S_INIT: begin
                req_d   = 1'b1;
                phase_d = PH_INIT;
            end
            S_COLLIDE: begin
                req_d   = 1'b1;
                phase_d = PH_COLLIDE;
            end
            S_MOVE: begin
                req_d   = 1'b1;
                phase_d = PH_MOVE;
            end
            S_SPAWN: begin
                req_d   = 1'b1;
                phase_d = PH_SPAWN;
            end
            S_DONE: begin
                tick_done_d = 1'b1;
            end
            default: begin
                req_d = 1'b0;
            end
        endcase
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_RST;
            gap_tgt_q      <= S_IDLE;
            wait_q         <= '0;
            retry_q        <= '0;
            score_q        <= '0;
            game_over_q    <= 1'b0;
            timeout_q      <= 1'b0;
            prev_restart_q <= 1'b0;
            req_q          <= 1'b0;
            phase_q        <= PH_NONE;
            tick_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            gap_tgt_q      <= gap_tgt_d;
            wait_q         <= wait_d;
            retry_q        <= retry_d;
            score_q        <= score_d;
            game_over_q    <= game_over_d;
            timeout_q      <= timeout_d;
            prev_restart_q <= i_restart;
            req_q          <= req_d;
            phase_q        <= phase_d;
            tick_done_q    <= tick_done_d;
        end
    end

    assign o_req       = req_q;
    assign o_phase     = phase_q;
    assign o_tick_done = tick_done_q;
    assign o_game_over = game_over_q;
    assign o_score     = score_q;
    assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_tick_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tick_sequencer
//   Directed bench for tick_sequencer. A second instance with SCORE_W=2
//   shares all stimulus so score saturation is checked alongside the default.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tick_sequencer;

    logic       clk;
    logic       rst_n;
    logic       i_tick;
    logic       i_restart;
    logic       i_ack;
    logic       i_result;
    logic       o_req;
    logic [2:0] o_phase;
    logic       o_tick_done;
    logic       o_game_over;
    logic [7:0] o_score;
    logic       o_timeout;

    logic       s2_req;
    logic [2:0] s2_phase;
    logic       s2_tick_done;
    logic       s2_game_over;
    logic [1:0] s2_score;
    logic       s2_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    tick_sequencer #(.SCORE_W(8), .ACK_TIMEOUT(15), .SPAWN_RETRIES(7)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_tick(i_tick), .i_restart(i_restart),
        .i_ack(i_ack), .i_result(i_result), .o_req(o_req), .o_phase(o_phase),
        .o_tick_done(o_tick_done), .o_game_over(o_game_over),
        .o_score(o_score), .o_timeout(o_timeout)
    );

    tick_sequencer #(.SCORE_W(2), .ACK_TIMEOUT(15), .SPAWN_RETRIES(7)) u_dut_s2 (
        .clk(clk), .rst_n(rst_n), .i_tick(i_tick), .i_restart(i_restart),
        .i_ack(i_ack), .i_result(i_result), .o_req(s2_req), .o_phase(s2_phase),
        .o_tick_done(s2_tick_done), .o_game_over(s2_game_over),
        .o_score(s2_score), .o_timeout(s2_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for the next request; reports how many cycles it took.
    task automatic wait_req(input string tag, output int waited);
        waited = 0;
        while (!o_req && waited < 30) begin
            step();
            waited++;
        end
        check({tag, "_req"}, 32'(o_req), 32'd1);
    endtask

    // Serve one phase: expect phase code, hold ack off for nack-1 cycles, ack.
    task automatic do_phase(input string tag, input logic [2:0] ph, input int nack,
                            input logic res, input int exp_wait);
        int   waited;
        logic held;
        wait_req(tag, waited);
        if (exp_wait >= 0) check({tag, "_gap"}, 32'(waited), 32'(exp_wait));
        check({tag, "_ph"}, 32'(o_phase), 32'(ph));
        held = 1'b1;
        for (int i = 1; i < nack; i++) begin
            step();
            held = held & o_req;
        end
        if (nack > 1) check({tag, "_hold"}, 32'(held), 32'd1);
        i_ack    = 1'b1;
        i_result = res;
        step();
        i_ack    = 1'b0;
        i_result = 1'b0;
        check({tag, "_drop"}, 32'(o_req), 32'd0);
    endtask

    // Currently in DONE: expect the pulse, drop the tick, expect it gone.
    task automatic finish_tick(input string tag);
        check({tag, "_done"}, 32'(o_tick_done), 32'd1);
        i_tick = 1'b0;
        step();
        check({tag, "_done_end"}, 32'(o_tick_done), 32'd0);
        check({tag, "_idle_req"}, 32'(o_req), 32'd0);
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        i_tick    = 1'b0;
        i_restart = 1'b0;
        i_ack     = 1'b0;
        i_result  = 1'b0;
        repeat (3) step();

        // Reset values.
        check("rst_req",   32'(o_req),       32'd0);
        check("rst_phase", 32'(o_phase),     32'd0);
        check("rst_done",  32'(o_tick_done), 32'd0);
        check("rst_go",    32'(o_game_over), 32'd0);
        check("rst_score", 32'(o_score),     32'd0);
        check("rst_to",    32'(o_timeout),   32'd0);

        // INIT acked on its third request cycle.
        rst_n = 1'b1;
        step();
        do_phase("t1_init", 3'd1, 3, 1'b0, 0);
        check("t1_phase", 32'(o_phase),     32'd0);
        check("t1_score", 32'(o_score),     32'd0);
        check("t1_go",    32'(o_game_over), 32'd0);

        // Full tick: collide miss, eat, spawn ok.
        i_tick = 1'b1;
        step();
        do_phase("t2_col", 3'd2, 2, 1'b0, 0);
        do_phase("t2_mov", 3'd3, 1, 1'b1, 1);
        check("t2_score", 32'(o_score), 32'd1);
        do_phase("t2_spn", 3'd4, 1, 1'b1, 1);
        finish_tick("t2");
        step();
        check("t2_single", 32'(o_tick_done), 32'd0);

        // Spawn fails every time: 8 attempts separated by one request-low cycle.
        i_tick = 1'b1;
        step();
        do_phase("t4_col", 3'd2, 1, 1'b0, 0);
        do_phase("t4_mov", 3'd3, 1, 1'b1, 1);
        for (int k = 0; k < 8; k++) begin
            do_phase($sformatf("t4_spn%0d", k), 3'd4, 1, 1'b0, 1);
            if (k < 7) check($sformatf("t4_nodone%0d", k), 32'(o_tick_done), 32'd0);
        end
        finish_tick("t4");
        check("t4_score", 32'(o_score),   32'd2);
        check("t4_to",    32'(o_timeout), 32'd0);

        // No ack in COLLIDE: forced completion after 15 cycles, then MOVE.
        i_tick = 1'b1;
        step();
        check("t5_ph", 32'(o_phase), 32'd2);
        n = 0;
        while (o_req && n < 40) begin
            n++;
            step();
        end
        check("t5_cycles", 32'(n),         32'd15);
        check("t5_to",     32'(o_timeout), 32'd1);
        do_phase("t5_mov", 3'd3, 1, 1'b0, 1);
        finish_tick("t5");
        check("t5_to_sticky", 32'(o_timeout), 32'd1);

        // Restart edge mid-MOVE coinciding with an ack; restart held 20 cycles.
        i_tick = 1'b1;
        step();
        do_phase("t6_col", 3'd2, 1, 1'b0, 0);
        wait_req("t6_mov", n);
        check("t6_mov_ph", 32'(o_phase), 32'd3);
        step();
        i_restart = 1'b1;
        i_ack     = 1'b1;
        i_result  = 1'b1;
        step();
        i_ack     = 1'b0;
        i_result  = 1'b0;
        check("t6_init_req", 32'(o_req),       32'd1);
        check("t6_init_ph",  32'(o_phase),     32'd1);
        check("t6_score",    32'(o_score),     32'd0);
        check("t6_s2score",  32'(s2_score),    32'd0);
        check("t6_to_clr",   32'(o_timeout),   32'd0);
        do_phase("t6_init", 3'd1, 4, 1'b0, 0);
        check("t6_idle_ph", 32'(o_phase), 32'd0);
        // The still-pending tick is serviced after INIT.
        do_phase("t6_col2", 3'd2, 1, 1'b0, 1);
        do_phase("t6_mov2", 3'd3, 1, 1'b1, 1);
        do_phase("t6_spn2", 3'd4, 1, 1'b1, 1);
        finish_tick("t6");
        repeat (8) step();
        check("t6_no_reinit", 32'(o_req), 32'd0);
        i_restart = 1'b0;
        step();
        check("t6_score_end", 32'(o_score),  32'd1);
        check("t6_s2_end",    32'(s2_score), 32'd1);

        // Four more eats: 8-bit score counts on, 2-bit score saturates at 3.
        for (int k = 0; k < 4; k++) begin
            i_tick = 1'b1;
            step();
            do_phase($sformatf("t7_col%0d", k), 3'd2, 1, 1'b0, 0);
            do_phase($sformatf("t7_mov%0d", k), 3'd3, 1, 1'b1, 1);
            check($sformatf("t7_score%0d", k), 32'(o_score),  32'(k + 2));
            check($sformatf("t7_s2sc%0d",  k), 32'(s2_score), 32'((k + 2 > 3) ? 3 : k + 2));
            do_phase($sformatf("t7_spn%0d", k), 3'd4, 1, 1'b1, 1);
            finish_tick($sformatf("t7_%0d", k));
        end

        // Collision ends the game; the next tick completes with no request.
        i_tick = 1'b1;
        step();
        do_phase("t3_col", 3'd2, 1, 1'b1, 0);
        check("t3_go", 32'(o_game_over), 32'd1);
        finish_tick("t3");
        i_tick = 1'b1;
        step();
        check("t3_go_req",  32'(o_req),   32'd0);
        check("t3_go_ph",   32'(o_phase), 32'd0);
        finish_tick("t3_go");
        check("t3_go_stay", 32'(o_game_over), 32'd1);

        // Restart from IDLE clears game over and score.
        i_restart = 1'b1;
        step();
        i_restart = 1'b0;
        check("t8_init_ph", 32'(o_phase),     32'd1);
        check("t8_go",      32'(o_game_over), 32'd0);
        check("t8_score",   32'(o_score),     32'd0);
        do_phase("t8_init", 3'd1, 2, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
